ac_multi_accumulator: RTL and testbench
=======================================

Name: ac_multi_accumulator

Overview:
- Multi-lane, frame-based accumulator: successor to the first-accumulator adder stage of the DP_CTRL datapath.
- Sums LEN accepted input beats per lane into registered results and presents them through a valid/ready output register.
- Accumulates the next frame while the previous result waits to be taken.
- Sits between the bit-adder/shift-register stage and the downstream accumulator or controller.

Parameters:
- M, 16: input-domain size; lane input width IN_W = $clog2(M)+1.
- N, 4: number of independent lanes.
- LEN, 8: accepted beats per frame; must be >= 1.
- ACC_W, $clog2(M)+1+$clog2(LEN): accumulator/result width per lane; must be >= IN_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous frame abort; clears the accumulators and the beat counter.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  N*IN_W  lane k at bits [k*IN_W +: IN_W]; unsigned.
- out_valid  output  1  result register holds an untaken frame result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  N*ACC_W  lane k at bits [k*ACC_W +: ACC_W]; unsigned.
- out_ovf  output  N  per-lane flag: the frame result overflowed ACC_W (wrapped or saturated).
- busy  output  1  beat counter is non-zero (frame in progress).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ovf=0, busy=0, accumulators=0, beat counter cnt=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-frame or with out_valid=1 discards everything.
- Beat accept: accept = in_valid & in_ready.
  - On accept with cnt<LEN-1: acc[k] <= acc[k] + in_data[k] (zero-extended to ACC_W), and cnt increments.
- Last beat: accept with cnt==LEN-1.
  - out_data[k] <= acc[k] + in_data[k].
  - out_ovf[k] <= carry out of that frame.
  - out_valid <= 1; acc <= 0; cnt <= 0.
  - Latency: result visible one cycle after the last beat is accepted.
- Overflow flag: per lane, sticky across the frame (any carry out of ACC_W during the frame). It is cleared at frame start.
- in_ready:
  - 0 when cnt==LEN-1 and out_valid==1 and out_ready==0; 1 otherwise.
  - out_ready is combinationally forwarded, so back-to-back frames run with no bubble.
- Output handshake: on out_valid & out_ready without a new last beat, out_valid <= 0.
  - A simultaneous take and last beat keeps out_valid=1 with the new data.
  - out_data and out_ovf stay stable while out_valid=1 and out_ready=0.
- LEN==1: every accepted beat is a last beat; cnt stays 0.
- clr:
  - Sets acc=0, cnt=0, and clears the sticky flags.
  - Any beat presented in the same cycle is dropped (in_ready is forced to 0 while clr=1).
  - Does not affect out_valid, out_data or out_ovf; a pending result survives clr.
- Priority: rst > clr > accept.
- Arithmetic: unsigned only. Without the optional feature, overflow wraps modulo 2^ACC_W.
- State encoding: FSM implied by {cnt, out_valid}.
  - IDLE: cnt=0, out_valid=0.
  - ACCUM: cnt>0.
  - HOLD: out_valid=1, result pending.
  - STALL: cnt==LEN-1 with the result pending and out_ready=0.

Optional Feature:
- Macro: AC_ACC_SATURATE_EN.
- Defined: each lane accumulator clamps at 2^ACC_W-1 on overflow, the result is the clamped value, and out_ovf still flags the lane.
- Undefined: wrap-around modulo 2^ACC_W; out_ovf reports the carry.
- The handshake and the latency are identical in both builds.

Test Plan:
- Basic frame (default params):
  - Stimulus: rst for 2 cycles, then 8 beats of lane values {1,2,3,4}, out_ready=1.
  - Response: out_data lanes {8,16,24,32} one cycle after beat 8; out_valid high for 1 cycle; out_ovf=0.
- Back-pressure:
  - Stimulus: hold out_ready=0 after frame 1, then stream frame 2.
  - Response: 7 beats accepted, then in_ready=0 on beat 8.
  - Response: after out_ready=1, frame-1 data is taken and the frame-2 sum appears the next cycle with no beat lost.
- Gapped input:
  - Stimulus: in_valid toggles 1/0 over 16 cycles, lane0 data=15.
  - Response: result 120 after the 8th accepted beat only.
- Overflow (ACC_W=5, LEN=4):
  - Stimulus: lane0 data=31 for 4 beats.
  - Response without the macro: out_data=28, out_ovf[0]=1.
  - Response with AC_ACC_SATURATE_EN: out_data=31, out_ovf[0]=1.
- clr mid-frame:
  - Stimulus: 3 beats of 5, clr for 1 cycle with in_valid=1, then 8 beats of 1.
  - Response: the beat during clr is dropped and the result is 8.
  - Response: a pending earlier result is unaffected.
- Reset mid-operation and LEN=1:
  - Stimulus: rst asserted with out_valid=1 and cnt=5.
  - Response: next cycle all outputs are 0 and in_ready=1.
  - Stimulus: with LEN=1, stream beats of 7.
  - Response: each beat is echoed as a result one cycle later.

Source files
------------

// File: rtl/ac_multi_accumulator.sv
// Multi-lane frame accumulator: sums LEN accepted beats per lane and hands the result through a valid/ready register.
// Optional build macro AC_ACC_SATURATE_EN: lanes clamp at all-ones instead of wrapping.

module ac_lane #(
   parameter int IN_W  = 5,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             accept,
   input  logic             last,
   input  logic [IN_W-1:0]  din,
   output logic [ACC_W-1:0] res,
   output logic             ovf
);
   logic [ACC_W-1:0] acc;
   logic             sticky;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] nxt;

   assign sum = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, din};

`ifdef AC_ACC_SATURATE_EN
   // once clamped, further unsigned adds keep carrying, so the lane stays pinned at all-ones
   assign nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign nxt = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         sticky <= 1'b0;
         res    <= '0;
         ovf    <= 1'b0;
      end else if (clr) begin
         acc    <= '0;
         sticky <= 1'b0;
      end else if (accept) begin
         if (last) begin
            res    <= nxt;
            ovf    <= sticky | sum[ACC_W];
            acc    <= '0;
            sticky <= 1'b0;
         end else begin
            acc    <= nxt;
            sticky <= sticky | sum[ACC_W];
         end
      end
   end
endmodule

module ac_multi_accumulator #(
   parameter int M     = 16,
   parameter int N     = 4,
   parameter int LEN   = 8,
   parameter int ACC_W = $clog2(M) + 1 + $clog2(LEN)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N*($clog2(M)+1)-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N*ACC_W-1:0]         out_data,
   output logic [N-1:0]               out_ovf,
   output logic                       busy
);
   localparam int IN_W  = $clog2(M) + 1;
   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   logic [CNT_W-1:0]           cnt;
   logic                       at_last;
   logic                       accept;
   logic [N-1:0][IN_W-1:0]     lane_in;
   logic [N-1:0][ACC_W-1:0]    lane_res;

   assign at_last  = (cnt == LAST);
   // a stalled last beat is released the same cycle downstream takes the pending result
   assign in_ready = ~clr & ~(at_last & out_valid & ~out_ready);
   assign accept   = in_valid & in_ready;
   assign busy     = (cnt != '0);
   assign lane_in  = in_data;
   assign out_data = lane_res;

   for (genvar k = 0; k < N; k++) begin : g_lane
      ac_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .clr    (clr),
         .accept (accept),
         .last   (at_last),
         .din    (lane_in[k]),
         .res    (lane_res[k]),
         .ovf    (out_ovf[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (clr) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= at_last ? '0 : cnt + CNT_W'(1);
         end
         if (accept && at_last) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ac_multi_accumulator.sv
// Bench for ac_multi_accumulator: frame-level reference model on a default instance plus directed overflow and LEN=1 instances.
module tb_ac_multi_accumulator;
   localparam int M = 16, N = 4, LEN = 8, IN_W = 5, ACC_W = 8;
   localparam int MAXV = (1 << ACC_W) - 1;

   logic clk = 0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // main instance
   logic rst, clr, in_valid, out_ready;
   logic [N*IN_W-1:0]  in_data;
   logic               in_ready, out_valid, busy;
   logic [N*ACC_W-1:0] out_data;
   logic [N-1:0]       out_ovf;

   ac_multi_accumulator #(.M(M), .N(N), .LEN(LEN)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ovf(out_ovf), .busy(busy));

   // overflow instance: one lane, ACC_W=5, LEN=4
   logic o_clr, o_vld, o_irdy, o_ovld, o_busy;
   logic [4:0] o_dat, o_odat;
   logic [0:0] o_ovf;
   ac_multi_accumulator #(.M(16), .N(1), .LEN(4), .ACC_W(5)) u_ovf (
      .clk(clk), .rst(rst), .clr(o_clr), .in_valid(o_vld), .in_ready(o_irdy),
      .in_data(o_dat), .out_valid(o_ovld), .out_ready(1'b1),
      .out_data(o_odat), .out_ovf(o_ovf), .busy(o_busy));

   // LEN=1 instance: two lanes
   logic l_clr, l_vld, l_ordy, l_irdy, l_ovld, l_busy;
   logic [9:0] l_dat, l_odat;
   logic [1:0] l_ovf;
   ac_multi_accumulator #(.M(16), .N(2), .LEN(1)) u_len1 (
      .clk(clk), .rst(rst), .clr(l_clr), .in_valid(l_vld), .in_ready(l_irdy),
      .in_data(l_dat), .out_valid(l_ovld), .out_ready(l_ordy),
      .out_data(l_odat), .out_ovf(l_ovf), .busy(l_busy));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*IN_W-1:0] pk(input int a, b, c, d);
      return {5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   function automatic logic [N*ACC_W-1:0] pr(input int a, b, c, d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // ---------------- reference model: true integer sums per frame ----------------
   int m_sum[N], m_res[N], m_cnt;
   bit m_ovf[N], m_vld, m_live;

   function automatic bit m_rdy();
      return !clr && !(m_cnt == LEN - 1 && m_vld && !out_ready);
   endfunction

   function automatic int fold(input int s);
`ifdef AC_ACC_SATURATE_EN
      return (s > MAXV) ? MAXV : s;
`else
      return s % (MAXV + 1);
`endif
   endfunction

   initial begin
      m_cnt = 0; m_vld = 0; m_live = 0;
      for (int k = 0; k < N; k++) begin m_sum[k] = 0; m_res[k] = 0; m_ovf[k] = 0; end
   end

   always @(posedge clk) begin
      bit acc, take, lastb;
      acc   = in_valid && m_rdy();
      take  = m_vld && out_ready;
      lastb = acc && (m_cnt == LEN - 1);
      m_live = 1;
      if (rst) begin
         m_cnt = 0; m_vld = 0;
         for (int k = 0; k < N; k++) begin m_sum[k] = 0; m_res[k] = 0; m_ovf[k] = 0; end
      end else begin
         if (clr) begin
            m_cnt = 0;
            for (int k = 0; k < N; k++) m_sum[k] = 0;
         end else if (acc) begin
            for (int k = 0; k < N; k++) m_sum[k] += int'(in_data[k*IN_W +: IN_W]);
            if (lastb) begin
               for (int k = 0; k < N; k++) begin
                  m_res[k] = fold(m_sum[k]);
                  m_ovf[k] = m_sum[k] > MAXV;
                  m_sum[k] = 0;
               end
               m_cnt = 0;
               m_vld = 1;
            end else m_cnt++;
         end
         if (take && !lastb) m_vld = 0;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         logic [N*ACC_W-1:0] ed;
         logic [N-1:0] eo;
         for (int k = 0; k < N; k++) begin
            ed[k*ACC_W +: ACC_W] = ACC_W'(m_res[k]);
            eo[k] = m_ovf[k];
         end
         chk("model out_valid", out_valid, m_vld);
         chk("model in_ready", in_ready, m_rdy());
         chk("model busy", busy, m_cnt != 0);
         chk("model out_data", out_data, ed);
         chk("model out_ovf", out_ovf, eo);
      end
   end

   task automatic ofr(input string nm, input int a, b, c, d, input int ed, input bit eo);
      int v[4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         o_vld = 1; o_dat = 5'(v[i]);
         step();
      end
      o_vld = 0;
      chk({nm, " valid"}, o_ovld, 1);
      chk({nm, " data"}, o_odat, ed);
      chk({nm, " ovf"}, o_ovf, eo);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; clr = 0; in_valid = 0; out_ready = 1; in_data = '0;
      o_clr = 0; o_vld = 0; o_dat = '0;
      l_clr = 0; l_vld = 0; l_ordy = 1; l_dat = '0;
      step(); step();
      rst = 0;
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset busy", busy, 0);
      chk("reset out_data", out_data, 0);

      // basic frame
      for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = pk(1, 2, 3, 4); step(); end
      in_valid = 0;
      chk("basic valid", out_valid, 1);
      chk("basic data", out_data, pr(8, 16, 24, 32));
      chk("basic ovf", out_ovf, 0);
      step();
      chk("basic valid one cycle", out_valid, 0);

      // back-pressure
      for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = pk(2, 2, 2, 2); step(); end
      out_ready = 0;
      for (int i = 0; i < 7; i++) begin in_valid = 1; in_data = pk(3, 3, 3, 3); step(); end
      chk("bp busy at 7", busy, 1);
      chk("bp stall in_ready", in_ready, 0);
      step(); step();
      chk("bp hold valid", out_valid, 1);
      chk("bp hold data", out_data, pr(16, 16, 16, 16));
      out_ready = 1;
      #1 chk("bp release in_ready", in_ready, 1);
      step();
      in_valid = 0;
      chk("bp frame2 valid", out_valid, 1);
      chk("bp frame2 data", out_data, pr(24, 24, 24, 24));
      step();
      chk("bp drained", out_valid, 0);

      // gapped input
      for (int i = 0; i < 16; i++) begin
         in_valid = (i % 2 == 0); in_data = pk(15, 0, 0, 0);
         step();
         chk("gap valid", out_valid, i == 14);
         if (i == 14) chk("gap data", out_data, pr(120, 0, 0, 0));
      end
      in_valid = 0;

      // clr mid-frame with a pending result
      out_ready = 0;
      for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = pk(4, 4, 4, 4); step(); end
      for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = pk(5, 5, 5, 5); step(); end
      clr = 1;
      #1 chk("clr in_ready", in_ready, 0);
      step();
      clr = 0; in_valid = 0;
      chk("clr busy", busy, 0);
      chk("clr pending valid", out_valid, 1);
      chk("clr pending data", out_data, pr(32, 32, 32, 32));
      out_ready = 1;
      step();
      for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = pk(1, 1, 1, 1); step(); end
      in_valid = 0;
      chk("clr new data", out_data, pr(8, 8, 8, 8));

      // reset mid-operation
      out_ready = 0;
      for (int i = 0; i < 8 + 5; i++) begin in_valid = 1; in_data = pk(1, 1, 1, 1); step(); end
      in_valid = 0;
      rst = 1; step(); rst = 0;
      chk("rst mid valid", out_valid, 0);
      chk("rst mid data", out_data, 0);
      chk("rst mid busy", busy, 0);
      chk("rst mid in_ready", in_ready, 1);
      out_ready = 1;

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clr       = ($urandom_range(0, 40) == 0);
         rst       = ($urandom_range(0, 600) == 0);
         in_data   = pk($urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 31), $urandom_range(0, 31));
         step();
      end
      rst = 0; clr = 0; in_valid = 0; out_ready = 1;
      step();

      // overflow instance
`ifdef AC_ACC_SATURATE_EN
      ofr("ovf 31x4", 31, 31, 31, 31, 31, 1);
      ofr("ovf none", 3, 3, 3, 3, 12, 0);
      ofr("ovf mid", 31, 31, 0, 0, 31, 1);
      ofr("ovf edge", 31, 1, 0, 0, 31, 1);
`else
      ofr("ovf 31x4", 31, 31, 31, 31, 28, 1);
      ofr("ovf none", 3, 3, 3, 3, 12, 0);
      ofr("ovf mid", 31, 31, 0, 0, 30, 1);
      ofr("ovf edge", 31, 1, 0, 0, 0, 1);
`endif
      for (int i = 0; i < 2; i++) begin o_vld = 1; o_dat = 5'd31; step(); end
      chk("ovf busy", o_busy, 1);
      o_clr = 1; o_vld = 0; step(); o_clr = 0;
      chk("ovf clr busy", o_busy, 0);
      ofr("ovf after clr", 1, 1, 1, 1, 4, 0);
      step();

      // LEN=1: each beat echoed one cycle later
      for (int i = 0; i < 12; i++) begin
         logic [4:0] r;
         r = 5'($urandom_range(0, 31));
         l_vld = 1; l_dat = {r, 5'd7};
         step();
         chk("len1 valid", l_ovld, 1);
         chk("len1 data", l_odat, {r, 5'd7});
         chk("len1 busy", l_busy, 0);
      end
      l_ordy = 0;
      #1 chk("len1 stall in_ready", l_irdy, 0);
      l_dat = {5'd9, 5'd9};
      step();
      chk("len1 stall data", l_odat, {5'd0, 5'd0} | {l_odat[9:5], 5'd7});
      chk("len1 stall lane0 kept", l_odat[4:0], 7);
      l_ordy = 1;
      step();
      l_vld = 0;
      chk("len1 release data", l_odat, {5'd9, 5'd9});
      step();
      chk("len1 drained", l_ovld, 0);
      chk("len1 ovf", l_ovf, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
